serial_word_feeder: RTL and testbench



---
 rtl/serial_pkg.sv | 11 +
 rtl/word_fifo2.sv | 50 +++++
 rtl/serial_word_feeder.sv | 83 ++++++++
 tb/tb_serial_word_feeder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial feeder and the complement shift stage.
package serial_pkg;

    localparam int SER_WIDTH = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with wrapping 1-bit pointers and an occupancy count.
module word_fifo2
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Requests that would overflow or underflow are ignored.
    assign do_push = push && !full;
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];
    assign full = (count == 2'd2);

endmodule

// File: rtl/serial_word_feeder.sv
// Buffers parallel words and streams them LSB-first as framed bits with back-pressure.
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_eof,
    input  logic             ser_ready,
    output logic [CNT_W-1:0] words_sent
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] head;
    logic [1:0]       count;
    logic             full;
    logic             push;
    logic             pop;
    logic             shifting;
    logic             take;
    logic             last_bit;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign shifting = (state == ST_SHIFT);
    assign take     = shifting && ser_ready;
    assign last_bit = (bit_idx == LAST_IDX);
    // Refill either from idle or on the edge that retires the eof bit, so words abut.
    assign pop      = (count != 2'd0) && (!shifting || (take && last_bit));

    word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .head    (head),
        .count   (count),
        .full    (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            words_sent <= '0;
        end else begin
            if (pop) begin
                state   <= ST_SHIFT;
                bit_idx <= '0;
            end else if (take) begin
                if (last_bit) state <= ST_IDLE;
                else          bit_idx <= bit_idx + 1'b1;
            end
            if (take && last_bit) words_sent <= words_sent + 1'b1;
        end
    end

    // Shift register holds data only; outputs are gated by state so it needs no reset.
    always_ff @(posedge clk) begin
        if (pop)                    sh <= head;
        else if (take && !last_bit) sh <= sh >> 1;
    end

    assign ser_valid = shifting;
    assign ser_bit   = shifting && sh[0];
    assign ser_sof   = shifting && (bit_idx == '0);
    assign ser_eof   = shifting && last_bit;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench with a bit-queue reference model checked every cycle.
module tb_serial_word_feeder;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_bit;
    logic             ser_valid;
    logic             ser_sof;
    logic             ser_eof;
    logic             ser_ready = 1'b1;
    logic [CNT_W-1:0] words_sent;

    int n_vec = 0;
    int n_err = 0;

    serial_word_feeder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_bit    (ser_bit),
        .ser_valid  (ser_valid),
        .ser_sof    (ser_sof),
        .ser_eof    (ser_eof),
        .ser_ready  (ser_ready),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word becomes WIDTH queued bits; the head of the queue
    // is what the output must show whenever ser_valid is high.
    logic             q_bit[$];
    int               q_pos[$];
    int               acc_cnt = 0;
    int               done_cnt = 0;
    logic [CNT_W-1:0] m_ws = '0;
    int               occ;
    int               prev_occ = 0;
    logic             prev_valid = 1'b0;
    logic             prev_eof_taken = 1'b0;
    logic             have_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_ser_valid", 32'(ser_valid), 32'd0);
            chk("rst_ser_bit", 32'(ser_bit), 32'd0);
            chk("rst_ser_sof", 32'(ser_sof), 32'd0);
            chk("rst_ser_eof", 32'(ser_eof), 32'd0);
            chk("rst_words_sent", 32'(words_sent), 32'd0);
            q_bit.delete();
            q_pos.delete();
            acc_cnt   = 0;
            done_cnt  = 0;
            m_ws      = '0;
            have_prev = 1'b0;
        end else begin
            // Words held in the buffer = accepted - finished - the one being shifted out.
            occ = acc_cnt - done_cnt - int'(ser_valid);
            chk("in_ready", 32'(in_ready), 32'(occ < 2));
            chk("words_sent", 32'(words_sent), 32'(m_ws));
            if (have_prev && prev_occ > 0 && (!prev_valid || prev_eof_taken)) begin
                chk("load_valid", 32'(ser_valid), 32'd1);
                chk("load_sof", 32'(ser_sof), 32'd1);
            end
            if (have_prev && prev_occ == 0 && !prev_valid)
                chk("idle_stays", 32'(ser_valid), 32'd0);
            if (!ser_valid) begin
                chk("idle_bit", 32'(ser_bit), 32'd0);
                chk("idle_sof", 32'(ser_sof), 32'd0);
                chk("idle_eof", 32'(ser_eof), 32'd0);
            end else if (q_bit.size() == 0) begin
                chk("spurious_valid", 32'(ser_valid), 32'd0);
            end else begin
                chk("ser_bit", 32'(ser_bit), 32'(q_bit[0]));
                chk("ser_sof", 32'(ser_sof), 32'(q_pos[0] == 0));
                chk("ser_eof", 32'(ser_eof), 32'(q_pos[0] == WIDTH - 1));
            end
            prev_occ       = occ;
            prev_valid     = ser_valid;
            prev_eof_taken = ser_valid && ser_ready && q_bit.size() > 0 && q_pos[0] == WIDTH - 1;
            have_prev      = 1'b1;
            if (in_valid && in_ready) begin
                for (int i = 0; i < WIDTH; i++) begin
                    q_bit.push_back(in_data[i]);
                    q_pos.push_back(i);
                end
                acc_cnt++;
            end
            if (ser_valid && ser_ready && q_bit.size() > 0) begin
                if (q_pos[0] == WIDTH - 1) begin
                    done_cnt++;
                    m_ws = m_ws + 1'b1;
                end
                void'(q_bit.pop_front());
                void'(q_pos.pop_front());
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] w);
        logic ok;
        ok       = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_sof(input string name);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (ser_valid && ser_sof) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(name, 32'(ser_valid), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  cap4, sof4, eof4;
        logic [11:0] cap12, val12;
        logic [2:0]  cap3, eof3;
        logic        saw_full;
        int          first_k, last_k, nb;

        // Reset and idle behaviour
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t1_in_ready", 32'(in_ready), 32'd1);
            chk("t1_ser_valid", 32'(ser_valid), 32'd0);
            chk("t1_words_sent", 32'(words_sent), 32'd0);
        end

        // Single word 1010
        @(posedge clk);
        #1;
        send(4'b1010);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_latency", 32'(ser_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cap4[i] = ser_bit;
            sof4[i] = ser_sof;
            eof4[i] = ser_eof;
        end
        chk("t2_bits", 32'(cap4), 32'h5 << 1);
        chk("t2_sof", 32'(sof4), 32'b0001);
        chk("t2_eof", 32'(eof4), 32'b1000);
        @(negedge clk);
        chk("t2_done_valid", 32'(ser_valid), 32'd0);
        chk("t2_ws", 32'(words_sent), 32'd1);

        // Back-to-back A, 3, F
        reset_pulse();
        saw_full = 1'b0;
        first_k  = -1;
        last_k   = -1;
        nb       = 0;
        cap12    = '0;
        val12    = '0;
        fork
            begin
                send(4'hA);
                send(4'h3);
                send(4'hF);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    @(negedge clk);
                    if (!in_ready) saw_full = 1'b1;
                    if (ser_valid && nb < 12) begin
                        if (first_k < 0) first_k = k;
                        last_k      = k;
                        cap12[nb]   = ser_bit;
                        val12[nb]   = 1'b1;
                        nb++;
                    end
                end
            end
        join
        chk("t3_bits", 32'(cap12), 32'hF3A);
        chk("t3_count", 32'(val12), 32'hFFF);
        chk("t3_contiguous", 32'(last_k - first_k), 32'd11);
        chk("t3_full_seen", 32'(saw_full), 32'd1);
        chk("t3_ws", 32'(words_sent), 32'd3);

        // Stall on bit 1 of 4'h6
        reset_pulse();
        send(4'h6);
        in_valid = 1'b0;
        wait_sof("t4_start");
        chk("t4_bit0", 32'(ser_bit), 32'd0);
        @(posedge clk);
        #1 ser_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(ser_valid), 32'd1);
            chk("t4_hold_bit", 32'(ser_bit), 32'd1);
            chk("t4_hold_sof", 32'(ser_sof), 32'd0);
            chk("t4_hold_eof", 32'(ser_eof), 32'd0);
        end
        @(posedge clk);
        #1 ser_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cap3[i] = ser_bit;
            eof3[i] = ser_eof;
        end
        chk("t4_resume_bits", 32'(cap3), 32'b011);
        chk("t4_resume_eof", 32'(eof3), 32'b100);
        @(negedge clk);
        chk("t4_ws", 32'(words_sent), 32'd1);

        // 256 words streamed continuously; counter wraps on the last eof
        reset_pulse();
        fork
            begin
                for (int i = 0; i < 256; i++) send(4'(i));
                in_valid = 1'b0;
            end
            begin
                logic ok;
                int   n, cyc;
                logic [CNT_W-1:0] ws_last;
                ok      = 1'b0;
                ws_last = '0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (ser_valid) begin
                        ok = 1'b1;
                        break;
                    end
                end
                chk("t5_start", 32'(ok), 32'd1);
                n   = 1;
                cyc = 1;
                while (n < 1024 && cyc < 1300) begin
                    @(negedge clk);
                    cyc++;
                    if (ser_valid) begin
                        n++;
                        if (n == 1021) ws_last = words_sent;
                    end
                end
                chk("t5_no_bubble", 32'(cyc), 32'd1024);
                chk("t5_ws_255", 32'(ws_last), 32'd255);
                @(negedge clk);
                chk("t5_ws_wrap", 32'(words_sent), 32'd0);
                chk("t5_end_idle", 32'(ser_valid), 32'd0);
            end
        join

        // Reset in the middle of 4'h9 with 4'h5 buffered
        reset_pulse();
        send(4'h9);
        send(4'h5);
        in_valid = 1'b0;
        wait_sof("t6_start");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_pre_valid", 32'(ser_valid), 32'd1);
        chk("t6_pre_bit2", 32'(ser_bit), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(ser_valid), 32'd0);
        chk("t6_async_bit", 32'(ser_bit), 32'd0);
        chk("t6_async_sof", 32'(ser_sof), 32'd0);
        chk("t6_async_eof", 32'(ser_eof), 32'd0);
        chk("t6_async_ready", 32'(in_ready), 32'd1);
        chk("t6_async_ws", 32'(words_sent), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("t6_after_valid", 32'(ser_valid), 32'd0);
            chk("t6_after_ws", 32'(words_sent), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
